// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit with one shared add/subtract datapath
// Ports: clk; reset (async, active-low); Start/Funct3/SrcA/SrcB request (sampled in IDLE);
//        Abort cancels the operation in flight; Busy high while an operation runs;
//        Done pulses for one cycle with Result valid; Result held until the next accepted Start.
// Macro MULDIV_EARLY_OUT_EN: divide-by-zero, signed overflow and zero multiply operands skip
//        the iteration and finish 2 cycles after Start.
module muldiv_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             Start,
   input  logic [2:0]       Funct3,
   input  logic [WIDTH-1:0] SrcA,
   input  logic [WIDTH-1:0] SrcB,
   input  logic             Abort,
   output logic             Busy,
   output logic             Done,
   output logic [WIDTH-1:0] Result
);
   localparam int CW = $clog2(WIDTH);
   localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
   localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
   typedef enum logic [2:0] {IDLE, PREP, ITER, FIX, DONE} state_t;
   state_t state, state_n;
   logic [2:0] f;
   logic [WIDTH-1:0] a, b;
   logic sa, sb, ovf;
   logic [2*WIDTH-1:0] acc, acc_step, prod;
   logic [CW-1:0] cnt;
   logic is_div, sign_a, sign_b, ovf_c, early, q_bit, neg;
   logic [WIDTH-1:0] mag_a, mag_b, quo, rem, fix_res, early_res;
   logic [WIDTH+1:0] add_a, add_b, sum;
   assign is_div = f[2];
   assign Busy = state != IDLE;
   assign Done = state == DONE;
   // Operand analysis; a/b still hold the raw operands while in PREP.
   always_comb begin
      sign_a = a[WIDTH-1] & ((f == 3'b001) | (f == 3'b010) | (f[2] & ~f[0]));
      sign_b = b[WIDTH-1] & ((f == 3'b001) | (f[2] & ~f[0]));
      mag_a = sign_a ? -a : a;
      mag_b = sign_b ? -b : b;
      ovf_c = f[2] & ~f[0] & (a == MIN_NEG) & (b == '1);
   end
   // Shared adder: multiply adds the multiplicand into the upper half; divide
   // trial-subtracts the divisor from the left-shifted remainder (one extra bit
   // so the borrow shows up in the MSB).
   always_comb begin
      add_a = is_div ? {1'b0, acc[2*WIDTH-1:WIDTH-1]} : {2'b0, acc[2*WIDTH-1:WIDTH]};
      add_b = is_div ? ~{2'b0, b} : {2'b0, a};
      sum = add_a + add_b + {{(WIDTH+1){1'b0}}, is_div};
      q_bit = ~sum[WIDTH+1];
      acc_step = is_div ? {q_bit ? sum[WIDTH-1:0] : acc[2*WIDTH-2:WIDTH-1], acc[WIDTH-2:0], q_bit}
                        : {acc[0] ? sum[WIDTH:0] : {1'b0, acc[2*WIDTH-1:WIDTH]}, acc[WIDTH-1:1]};
   end
   // Sign correction; a zero divisor must leave the all-ones quotient alone.
   always_comb begin
      neg = sa ^ sb;
      prod = neg ? -acc : acc;
      quo = ovf ? a : (neg & (b != '0)) ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
      rem = ovf ? '0 : sa ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
      fix_res = is_div ? (f[1] ? rem : quo)
                       : (f[1:0] == 2'b00 ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH]);
   end
`ifdef MULDIV_EARLY_OUT_EN
   assign early = is_div ? ((b == '0) | ovf_c) : ((a == '0) | (b == '0));
   assign early_res = !is_div ? '0 : f[1] ? (ovf_c ? '0 : a) : (ovf_c ? a : '1);
`else
   assign early = 1'b0;
   assign early_res = '0;
`endif
   always_ff @(posedge clk or negedge reset)
      if (!reset) state <= IDLE;
      else state <= state_n;
   always_comb begin
      state_n = state;
      if (Abort) state_n = IDLE;
      else case (state)
         IDLE: state_n = Start ? PREP : IDLE;
         PREP: state_n = early ? DONE : ITER;
         ITER: state_n = (cnt == LAST) ? FIX : ITER;
         FIX: state_n = DONE;
         default: state_n = IDLE;
      endcase
   end
   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         f <= '0;
         a <= '0;
         b <= '0;
         sa <= 1'b0;
         sb <= 1'b0;
         ovf <= 1'b0;
         acc <= '0;
         cnt <= '0;
         Result <= '0;
      end else begin
         if (state == IDLE && state_n == PREP) begin
            f <= Funct3;
            a <= SrcA;
            b <= SrcB;
         end
         if (state == PREP) begin
            sa <= sign_a;
            sb <= sign_b;
            ovf <= ovf_c;
            a <= mag_a;
            b <= mag_b;
            acc <= {{WIDTH{1'b0}}, is_div ? mag_a : mag_b};
            cnt <= '0;
         end
         if (state == ITER) begin
            acc <= acc_step;
            cnt <= cnt + CW'(1);
         end
         if (state_n == DONE) Result <= (state == FIX) ? fix_res : early_res;
      end
endmodule

// File: doc/muldiv_unit.md
# muldiv_unit

- Iterative RV32M multiply/divide execution unit with its own sequencing FSM.
- Sits beside the ALU in the execute stage. The main controller stalls the pipeline while `Busy` is high, then writes `Result` back when `Done` pulses.
- Uses one shared WIDTH-bit add/subtract datapath, stepped once per cycle: shift-add for multiply, restoring division for divide/remainder.

## Interface
- `WIDTH`, default 32: operand and result width.
- `clk` input 1: clock, rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `Start` input 1: request; sampled only in IDLE.
- `Funct3` input 3: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- `SrcA` input WIDTH: rs1 (multiplicand/dividend).
- `SrcB` input WIDTH: rs2 (multiplier/divisor).
- `Abort` input 1: pipeline flush; cancels the operation in flight.
- `Busy` output 1: high from the cycle after `Start` is accepted until `Done`, inclusive.
- `Done` output 1: one-cycle pulse; `Result` is valid in that cycle.
- `Result` output WIDTH: result; held until the next accepted `Start`.

## Operation
- States: IDLE, PREP, ITER, FIX, DONE.
- IDLE:
  - `Start`=1 latches `Funct3`, `SrcA` and `SrcB`, then goes to PREP.
  - `Start`=0 stays in IDLE.
- PREP (1 cycle):
  - Records the operand signs for signed variants: MULH/DIV/REM sign A and B; MULHSU sign A only.
  - Converts operands to magnitudes.
  - Clears the 2·WIDTH accumulator and the step counter.
- ITER (exactly WIDTH cycles):
  - Multiply: if the multiplier LSB is 1, add the multiplicand into the upper half; then shift the accumulator right 1.
  - Divide: shift the remainder:quotient left 1; trial-subtract the divisor magnitude; if non-negative, keep the difference and set quotient LSB=1.
  - The counter wraps from WIDTH-1 to FIX.
- FIX (1 cycle):
  - Multiply: negate the 2·WIDTH product if the operand signs differ.
  - Divide: negate the quotient if the signs differ; the remainder takes the dividend's sign.
  - Select the result: MUL low half, MULH* high half, DIV* quotient, REM* remainder.
- DONE (1 cycle): `Done`=1, `Result` driven, then return to IDLE.
- Divide by zero: quotient all ones; remainder = dividend. This falls out of restoring division on magnitudes; FIX must not negate the quotient when the divisor is zero.
- Signed overflow (DIV/REM with dividend = -2^(WIDTH-1) and divisor = -1): quotient = dividend, remainder = 0. PREP detects this case; FIX forces the values.
- `Start` while not in IDLE is ignored; there is no queuing.
- `Abort` in any non-IDLE state:
  - next state IDLE;
  - `Busy` low next cycle;
  - no `Done`;
  - `Result` keeps its previous value.
- `Abort` and `Start` in the same IDLE cycle: `Abort` wins and the request is dropped.
- Reset (asynchronous): state IDLE, `Busy`=0, `Done`=0, `Result`=0, all internal registers 0. Reset mid-operation discards the operation.

## Timing
- `Start` accepted at rising edge E0.
- `Busy`=1 from E0 until the edge that leaves DONE.
- State sequence: PREP after E0, ITER after E1 … E(WIDTH), FIX after E(WIDTH+1), DONE after E(WIDTH+2).
- `Done` pulse occupies the cycle after E(WIDTH+2); latency is WIDTH+3 cycles (35 for WIDTH=32).
- The earliest next `Start` is accepted at the edge ending the DONE cycle? No: it is accepted at the first edge in IDLE, one cycle after `Done`.
- `Result` is registered; it changes only on entry to DONE.

## Configuration
- `MULDIV_EARLY_OUT_EN` defined: PREP goes directly to DONE, with latency 2 cycles (`Done` after E1), when any of these hold:
  - divisor = 0 (divide/remainder);
  - signed overflow (DIV/REM);
  - either multiply operand = 0.
  
  Result values are identical to the full path.
- Not defined: every operation takes the fixed WIDTH+3 cycles.

## Test plan
- MUL `SrcA`=7, `SrcB`=0xFFFFFFFD → `Result`=0xFFFFFFEB; `Done` exactly 35 cycles after the Start edge; `Busy` high throughout.
- MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE. MULHSU 0xFFFFFFFF×2 → 0xFFFFFFFF.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD. REM with the same operands → 0xFFFFFFFF. DIVU 100/7 → 14. REMU 100/7 → 2.
- DIVU 5/0 → 0xFFFFFFFF; REM 5/0 → 5; DIV 0x80000000/0xFFFFFFFF → 0x80000000; REM with the same operands → 0.
  - With `MULDIV_EARLY_OUT_EN`: `Done` 2 cycles after the Start edge.
  - Without it: 35 cycles.
- `Abort` at cycle 10 of an operation → no `Done`, `Result` unchanged, `Busy` low next cycle. A `Start` one cycle later completes normally. A second `Start` while `Busy` is ignored.
- `reset` asserted low mid-ITER → all outputs 0 immediately (asynchronous). After release, a new MUL 3×4 → 12 with normal latency.
